// File: rtl/aiv_sync_decoder.sv
// AIV composite sync decoder: line/field strobes, X/Y counters and lock state from csync.
// Strobes trail the csync pin edge by 2 sync + GLITCH_CYCLES filter + 1 classify cycles; no backpressure.
module aiv_sync_decoder #(
  parameter int GLITCH_CYCLES = 4,
  parameter int SHORT_MAX     = 280,
  parameter int HSYNC_MAX     = 810,
  parameter int LINE_CYCLES   = 5184,
  parameter int BROAD_COUNT   = 5,
  parameter int LOCK_FIELDS   = 2
) (
  input  logic       sysClk,
  input  logic       nReset,
  input  logic [2:0] sysClkPhase,
  input  logic       csync,
  output logic       hsyncStrobe,
  output logic       vsyncStrobe,
  output logic       field,
  output logic [9:0] lineY,
  output logic [9:0] pixelX,
  output logic       locked
);

  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam int TO_CYCLES = 2 * LINE_CYCLES;
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam int BW = $clog2(BROAD_COUNT + 1);
  localparam int VW = $clog2(LOCK_FIELDS + 1);

  localparam logic [11:0] SHORT_W = 12'(SHORT_MAX);
  localparam logic [11:0] HSYNC_W = 12'(HSYNC_MAX);
  localparam logic [12:0] QTR_LO  = 13'(LINE_CYCLES / 4);
  localparam logic [12:0] QTR_HI  = 13'(3 * LINE_CYCLES / 4);

  typedef enum logic {P_HIGH, P_LOW} pulse_state_t;
  typedef enum logic {V_ACTIVE, V_BROAD} vert_state_t;

  logic          sync_a;
  logic          sync_b;
  logic          filt;
  logic          filt_d;
  logic [GW-1:0] glitch_cnt;
  logic          fall_evt;
  logic          rise_evt;

  pulse_state_t  pulse_q;
  pulse_state_t  pulse_nxt;
  vert_state_t   vert_q;
  vert_state_t   vert_nxt;

  logic [11:0]   width_cnt;
  logic [12:0]   line_cnt;
  logic [12:0]   fall_period;
  logic [TW-1:0] idle_cnt;
  logic [BW-1:0] broad_cnt;
  logic [VW-1:0] valid_cnt;
  logic          field_pend;

  logic          is_line;
  logic          is_broad;
  logic          first_broad;
  logic          field_done;
  logic          field_abort;
  logic          timeout_hit;
  logic          field_ok;

  // Idle level of csync is high, so the conditioning chain resets high to avoid a phantom edge.
  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      sync_a     <= 1'b1;
      sync_b     <= 1'b1;
      filt       <= 1'b1;
      filt_d     <= 1'b1;
      glitch_cnt <= '0;
    end else begin
      sync_a <= csync;
      sync_b <= sync_a;
      filt_d <= filt;
      if (sync_b != filt) begin
        if (glitch_cnt == GW'(GLITCH_CYCLES - 1)) begin
          filt       <= sync_b;
          glitch_cnt <= '0;
        end else begin
          glitch_cnt <= glitch_cnt + 1'b1;
        end
      end else begin
        glitch_cnt <= '0;
      end
    end
  end

  assign fall_evt    = filt_d & ~filt;
  assign rise_evt    = ~filt_d & filt;
  assign timeout_hit = ~(fall_evt | rise_evt) && (idle_cnt == TW'(TO_CYCLES - 1));
  assign field_ok    = (lineY >= 10'd310) && (lineY <= 10'd314);

  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      pulse_q <= P_HIGH;
      vert_q  <= V_ACTIVE;
    end else begin
      pulse_q <= pulse_nxt;
      vert_q  <= vert_nxt;
    end
  end

  always_comb begin
    pulse_nxt   = pulse_q;
    vert_nxt    = vert_q;
    is_line     = 1'b0;
    is_broad    = 1'b0;
    first_broad = 1'b0;
    field_done  = 1'b0;
    field_abort = 1'b0;

    case (pulse_q)
      P_HIGH: if (fall_evt) pulse_nxt = P_LOW;
      P_LOW: begin
        if (rise_evt) begin
          pulse_nxt = P_HIGH;
          is_line   = (width_cnt >= SHORT_W) && (width_cnt < HSYNC_W);
          is_broad  = (width_cnt >= HSYNC_W);
        end
      end
      default: pulse_nxt = P_HIGH;
    endcase

    case (vert_q)
      V_ACTIVE: begin
        if (is_broad) begin
          first_broad = 1'b1;
          vert_nxt    = V_BROAD;
        end
      end
      V_BROAD: begin
        if (is_broad && (broad_cnt == BW'(BROAD_COUNT - 1))) begin
          field_done = 1'b1;
          vert_nxt   = V_ACTIVE;
        end else if (is_line) begin
          field_abort = 1'b1;
          vert_nxt    = V_ACTIVE;
        end
      end
      default: vert_nxt = V_ACTIVE;
    endcase

    if (timeout_hit) begin
      pulse_nxt = P_HIGH;
      vert_nxt  = V_ACTIVE;
    end
  end

  // fall_period keeps the fall-to-fall spacing so the field can be judged at the broad pulse's rise.
  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      width_cnt   <= '0;
      line_cnt    <= '0;
      fall_period <= '0;
      idle_cnt    <= '0;
    end else begin
      if (fall_evt) begin
        width_cnt   <= '0;
        line_cnt    <= '0;
        fall_period <= line_cnt;
      end else begin
        if ((pulse_q == P_LOW) && (width_cnt != 12'hFFF)) width_cnt <= width_cnt + 1'b1;
        if (line_cnt != 13'h1FFF) line_cnt <= line_cnt + 1'b1;
      end
      if (fall_evt || rise_evt) idle_cnt <= '0;
      else if (idle_cnt != TW'(TO_CYCLES)) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      broad_cnt  <= '0;
      field_pend <= 1'b0;
    end else begin
      if (field_done || field_abort || timeout_hit) broad_cnt <= '0;
      else if (first_broad) broad_cnt <= BW'(1);
      else if ((vert_q == V_BROAD) && is_broad) broad_cnt <= broad_cnt + 1'b1;
      if (first_broad) field_pend <= ~((fall_period < QTR_LO) || (fall_period > QTR_HI));
    end
  end

  // Counter updates land on the same edge that raises the matching strobe.
  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      hsyncStrobe <= 1'b0;
      vsyncStrobe <= 1'b0;
      field       <= 1'b0;
      lineY       <= '0;
      pixelX      <= '0;
    end else begin
      hsyncStrobe <= is_line;
      vsyncStrobe <= field_done;
      if (field_done) field <= field_pend;
      if (field_done) lineY <= '0;
      else if (is_line && (lineY != 10'd1023)) lineY <= lineY + 1'b1;
      if (is_line) pixelX <= '0;
      else if ((sysClkPhase == 3'd0) && (pixelX != 10'd1023)) pixelX <= pixelX + 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (!nReset) begin
      valid_cnt <= '0;
      locked    <= 1'b0;
    end else if (timeout_hit) begin
      valid_cnt <= '0;
      locked    <= 1'b0;
    end else if (field_done) begin
      if (field_ok) begin
        if (valid_cnt != VW'(LOCK_FIELDS)) valid_cnt <= valid_cnt + 1'b1;
        locked <= (valid_cnt >= VW'(LOCK_FIELDS - 1));
      end else begin
        valid_cnt <= '0;
        locked    <= 1'b0;
      end
    end else if (field_abort) begin
      locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aiv_sync_decoder.sv
// Scoreboard bench for aiv_sync_decoder on a shortened line (24 cycles) so full 312-line fields fit quickly.
module tb_aiv_sync_decoder;

  localparam int LINE      = 24;
  localparam int LOW_LINE  = 6;
  localparam int LOW_BROAD = 14;
  localparam int LAT       = 7;

  logic       sysClk = 1'b0;
  logic       nReset = 1'b0;
  logic [2:0] sysClkPhase = 3'd0;
  logic       csync = 1'b1;
  logic       hsyncStrobe;
  logic       vsyncStrobe;
  logic       field;
  logic [9:0] lineY;
  logic [9:0] pixelX;
  logic       locked;

  aiv_sync_decoder #(
    .GLITCH_CYCLES(4),
    .SHORT_MAX    (4),
    .HSYNC_MAX    (10),
    .LINE_CYCLES  (LINE),
    .BROAD_COUNT  (5),
    .LOCK_FIELDS  (2)
  ) u_dut (
    .sysClk     (sysClk),
    .nReset     (nReset),
    .sysClkPhase(sysClkPhase),
    .csync      (csync),
    .hsyncStrobe(hsyncStrobe),
    .vsyncStrobe(vsyncStrobe),
    .field      (field),
    .lineY      (lineY),
    .pixelX     (pixelX),
    .locked     (locked)
  );

  initial forever #5 sysClk = ~sysClk;

  typedef struct {
    logic [1:0] kind;
    int         cyc;
    int         ly;
    logic       fld;
    logic       lck;
    logic       chk_lck;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  post_e;
  logic post_vld = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_ly = 0;
  logic phase_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysClk);
      #1;
      if (!phase_hold) sysClkPhase = (sysClkPhase == 3'd5) ? 3'd0 : sysClkPhase + 3'd1;
    end
  endtask

  task automatic line_pulse(input int period);
    csync = 1'b0;
    tick(LOW_LINE);
    csync = 1'b1;
    if (exp_ly < 1023) exp_ly++;
    exp_q.push_back('{2'b01, cyc + LAT, exp_ly, 1'b0, 1'b0, 1'b0});
    tick(period - LOW_LINE);
  endtask

  task automatic broad_pulse(input bit last, input logic fld, input logic lck, input bit chk_lck);
    csync = 1'b0;
    tick(LOW_BROAD);
    csync = 1'b1;
    if (last) begin
      exp_ly = 0;
      exp_q.push_back('{2'b10, cyc + LAT, 0, fld, lck, chk_lck});
    end
    tick(LINE - LOW_BROAD);
  endtask

  task automatic run_field(input int nl, input bit midline, input logic fld, input logic lck, input bit chk_lck);
    for (int i = 0; i < nl; i++) line_pulse((midline && i == nl - 1) ? LINE / 2 : LINE);
    for (int b = 0; b < 5; b++) broad_pulse(b == 4, fld, lck, chk_lck);
    chk("field_q_drained", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, hsyncStrobe, 0);
    chk({tag, "_vsync"}, vsyncStrobe, 0);
    chk({tag, "_field"}, field, 0);
    chk({tag, "_lineY"}, lineY, 0);
    chk({tag, "_pixelX"}, pixelX, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  initial forever begin
    @(posedge sysClk);
    cyc++;
  end

  // Monitor: pops one expected event per strobe; registered side effects are checked a cycle later.
  initial forever begin
    ev_t e;
    @(negedge sysClk);
    if (post_vld) begin
      post_vld = 1'b0;
      if (post_e.kind == 2'b10) begin
        chk("vs_lineY", lineY, post_e.ly);
        chk("vs_field", field, post_e.fld);
        if (post_e.chk_lck) chk("vs_locked", locked, post_e.lck);
      end else begin
        chk("hs_lineY", lineY, post_e.ly);
        chk("hs_pixelX_cleared", 32'(pixelX <= 10'd1), 1);
      end
    end
    if (hsyncStrobe || vsyncStrobe) begin
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", {30'd0, vsyncStrobe, hsyncStrobe}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", {30'd0, vsyncStrobe, hsyncStrobe}, {30'd0, e.kind});
        if (e.kind == 2'b01) chk("hs_latency", cyc, e.cyc);
        else chk("vs_latency_window", 32'((cyc >= e.cyc) && (cyc <= e.cyc + 1)), 1);
        post_e   = e;
        post_vld = 1'b1;
      end
    end
  end

  initial begin
    tick(3);
    chk_reset_outputs("reset");
    nReset = 1'b1;
    tick(5);

    // Regular line syncs.
    for (int i = 0; i < 3; i++) line_pulse(LINE);
    chk("lines_q_empty", exp_q.size(), 0);
    chk("lines_lineY", lineY, 3);

    // Glitches and an equalising-width pulse with pixel phase frozen off zero.
    phase_hold  = 1'b1;
    sysClkPhase = 3'd1;
    line_pulse(LINE);
    for (int g = 1; g <= 3; g++) begin
      csync = 1'b0;
      tick(g);
      csync = 1'b1;
      tick(20);
    end
    csync = 1'b0;
    tick(4);
    csync = 1'b1;
    tick(20);
    chk("glitch_lineY", lineY, 4);
    chk("glitch_pixelX", pixelX, 0);
    chk("glitch_q_empty", exp_q.size(), 0);

    // pixelX advances only on phase 0 and saturates.
    sysClkPhase = 3'd0;
    tick(10);
    chk("pixelX_count", pixelX, 10);
    tick(1090);
    chk("pixelX_saturate", pixelX, 1023);
    sysClkPhase = 3'd1;
    phase_hold  = 1'b0;

    // Two line-aligned 312-line fields: lock after the second.
    run_field(312 - exp_ly, 1'b0, 1'b0, 1'b0, 1'b1);
    run_field(312, 1'b0, 1'b0, 1'b1, 1'b1);

    // Mid-line broad start gives the second field.
    run_field(312, 1'b1, 1'b1, 1'b1, 1'b1);

    // Aborted field sync.
    for (int i = 0; i < 10; i++) line_pulse(LINE);
    chk("pre_abort_locked", locked, 1);
    for (int b = 0; b < 3; b++) broad_pulse(1'b0, 1'b0, 1'b0, 1'b0);
    line_pulse(LINE);
    chk("abort_locked", locked, 0);
    chk("abort_lineY", lineY, 11);
    run_field(312 - exp_ly, 1'b0, 1'b0, 1'b1, 1'b1);

    // Loss of sync timeout while locked.
    for (int i = 0; i < 5; i++) line_pulse(LINE);
    tick(12);
    chk("pre_timeout_locked", locked, 1);
    tick(40);
    chk("timeout_locked", locked, 0);
    chk("timeout_lineY_hold", lineY, exp_ly);
    line_pulse(LINE);
    chk("post_timeout_lineY", lineY, 6);

    // Reset in the middle of a sync pulse.
    for (int i = 0; i < 3; i++) line_pulse(LINE);
    csync = 1'b0;
    tick(3);
    nReset = 1'b0;
    exp_q.delete();
    post_vld = 1'b0;
    exp_ly = 0;
    tick(1);
    chk_reset_outputs("midfield_reset");
    csync = 1'b1;
    tick(3);
    nReset = 1'b1;
    tick(5);

    // Short field after reset is not a valid field.
    run_field(20, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("final_locked", locked, 0);
    tick(20);
    chk("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
